// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_LSL   = 4'b1000;
    localparam logic [3:0] OP_LSR   = 4'b1001;
    localparam logic [3:0] OP_ASR   = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1101;
    localparam logic [3:0] OP_UDIV  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    // An op goes down the iterative path only when its unit is built in.
    function automatic logic is_iter(input logic [3:0] op, input logic mul_en, input logic div_en);
        return (op == OP_MUL && mul_en) || (op == OP_UDIV && div_en);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: radix-2 shift-add multiply (low N bits) or restoring unsigned divide, N cycles.
module alu_muldiv_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         dz
);

    localparam int CW = $clog2(N) + 1;

    // acc: partial product (mul) / partial remainder (div)
    // x:   shifted multiplicand (mul) / dividend shifting into quotient (div)
    // y:   multiplier shifting right (mul) / divisor (div)
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc, x, y;
    logic          md;
    logic [N:0]    rem_sh;
    logic          ge;

    assign rem_sh = {acc, x[N-1]};
    assign ge     = (rem_sh >= {1'b0, y});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            acc  <= '0;
            x    <= '0;
            y    <= '0;
            md   <= 1'b0;
            dz   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt  <= CW'(N);
                acc  <= '0;
                x    <= a;
                y    <= b;
                md   <= mode;
                dz   <= mode && (b == '0);
                busy <= 1'b1;
            end else if (busy) begin
                if (!md) begin
                    if (y[0]) acc <= acc + x;
                    x <= x << 1;
                    y <= y >> 1;
                end else begin
                    acc <= ge ? rem_sh[N-1:0] - y : rem_sh[N-1:0];
                    x   <= {x[N-2:0], ge};
                end
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Divide-by-zero would produce all-ones from the restoring loop; report zero instead.
    assign result = md ? (dz ? '0 : x) : acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift unit plus iterative MUL/UDIV, NZCV flags, valid/ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N      = 64,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    input  logic [3:0]   operation,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] output1,
    output logic         z,
    output logic         n,
    output logic         c,
    output logic         v,
    output logic         dz,
    output logic         err
);

    localparam int SW = $clog2(N);

    state_t         state, state_nx;
    logic [N-1:0]   opa, opb;
    logic [3:0]     opc;
    logic [3:0]     flg;
    logic           accept, it_start, it_busy, it_done, it_dz, it_fin;
    logic [N-1:0]   it_res;

    // DONE is entered on the accept edge; the result register fills one edge later,
    // so a new accept waits until the result is actually presented.
    assign in_ready = (state == IDLE) || (state == DONE && out_valid && out_ready);
    assign accept   = in_valid && in_ready;
    assign it_start = accept && is_iter(operation, MUL_EN, DIV_EN);
    assign it_fin   = it_done && !it_busy;

    alu_muldiv_iter #(.N(N)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (it_start),
        .mode   (operation == OP_UDIV),
        .a      (input1),
        .b      (input2),
        .busy   (it_busy),
        .done   (it_done),
        .result (it_res),
        .dz     (it_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = it_start ? BUSY : DONE;
        end else begin
            case (state)
                BUSY:    if (it_fin) state_nx = DONE;
                DONE:    if (out_valid && out_ready) state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    logic [SW-1:0] sh;
    logic [N:0]    add_w, sub_w, lsl_w, lsr_w, asr_w;
    logic [N-1:0]  s_res;
    logic          s_c, s_v, s_err;

    assign sh    = opb[SW-1:0];
    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} - {1'b0, opb};
    assign lsl_w = {1'b0, opa} << sh;
    assign lsr_w = {opa, 1'b0} >> sh;
    assign asr_w = $signed({opa, 1'b0}) >>> sh;

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_err = 1'b0;
        case (opc)
            OP_AND:   s_res = opa & opb;
            OP_OR:    s_res = opa | opb;
            OP_XOR:   s_res = opa ^ opb;
            OP_NOR:   s_res = ~(opa | opb);
            OP_PASSB: s_res = opb;
            OP_ADD: begin
                s_res = add_w[N-1:0];
                s_c   = add_w[N];
                s_v   = (opa[N-1] == opb[N-1]) && (add_w[N-1] != opa[N-1]);
            end
            OP_SUB: begin
                s_res = sub_w[N-1:0];
                s_c   = !sub_w[N];
                s_v   = (opa[N-1] != opb[N-1]) && (sub_w[N-1] != opa[N-1]);
            end
            OP_LSL:  {s_c, s_res} = lsl_w;
            OP_LSR:  {s_res, s_c} = lsr_w;
            OP_ASR:  {s_res, s_c} = asr_w;
            default: s_err = 1'b1;  // illegal, or MUL/UDIV built out
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            opc       <= '0;
            out_valid <= 1'b0;
            output1   <= '0;
            flg       <= '0;
            dz        <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            opa       <= input1;
            opb       <= input2;
            opc       <= operation;
            out_valid <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
        end else if (state == DONE && !out_valid) begin
            output1    <= s_res;
            flg[FLG_Z] <= (s_res == '0);
            flg[FLG_N] <= s_res[N-1];
            flg[FLG_C] <= s_c;
            flg[FLG_V] <= s_v;
            err        <= s_err;
            out_valid  <= 1'b1;
        end else if (state == BUSY && it_fin) begin
            output1    <= it_res;
            flg[FLG_Z] <= (it_res == '0);
            flg[FLG_N] <= it_res[N-1];
            flg[FLG_C] <= 1'b0;
            flg[FLG_V] <= 1'b0;
            dz         <= it_dz;
            out_valid  <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign z = flg[FLG_Z];
    assign n = flg[FLG_N];
    assign c = flg[FLG_C];
    assign v = flg[FLG_V];

endmodule
